data_memory: RTL and testbench



---
 rtl/mem_pkg.sv | 11 +
 rtl/data_memory.sv | 59 +++++
 tb/tb_data_memory.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared constants for the CPU data memory: word/byte geometry and the
// number of low address bits dropped to form a word-aligned address.
package mem_pkg;

  localparam int WORD_W         = 32;
  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = WORD_W / BYTE_W;
  localparam int DEFAULT_DEPTH  = 32;
  localparam int ADDR_LSB       = 2;

endpackage : mem_pkg

// File: rtl/data_memory.sv
// Byte-addressed, little-endian data memory for the CPU memory stage.
// One word access per cycle: synchronous write, combinational read.
// The storage array is reached hierarchically as `memory` by benches and
// top-level dumps, so its name and shape must stay as they are.
module data_memory
  import mem_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [WORD_W-1:0] RDaddr_i,
  input  logic [WORD_W-1:0] RDdata_i,
  input  logic              MemWrite_i,
  input  logic              MemRead_i,
  output logic [WORD_W-1:0] RDdata_o
);

  localparam int AW = $clog2(DEPTH);

  reg [7:0] memory [0:DEPTH-1];

  logic [WORD_W-1:0] ea;
  logic [WORD_W:0]   ea_last;
  logic              in_range;
  logic [AW-1:0]     base;

  // Word-aligned effective address; the last byte is computed one bit wider
  // so addresses near 2^32 can never wrap back into range.
  assign ea       = {RDaddr_i[WORD_W-1:ADDR_LSB], {ADDR_LSB{1'b0}}};
  assign ea_last  = {1'b0, ea} + (WORD_W+1)'(BYTES_PER_WORD - 1);
  assign in_range = (ea_last < (WORD_W+1)'(DEPTH));
  assign base     = ea[AW-1:0];

  // Storage: async clear on reset, otherwise a full-word little-endian write.
  // An X on MemWrite_i makes the if-condition false, so memory is untouched.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        memory[AW'(i)] <= '0;
      end
    end else if (MemWrite_i == 1'b1 && in_range) begin
      for (int k = 0; k < BYTES_PER_WORD; k++) begin
        memory[base + AW'(k)] <= RDdata_i[k*BYTE_W +: BYTE_W];
      end
    end
  end

  // Combinational read mux; zero when disabled or out of range.
  always_comb begin
    RDdata_o = '0;
    if (MemRead_i && in_range) begin
      for (int k = 0; k < BYTES_PER_WORD; k++) begin
        RDdata_o[k*BYTE_W +: BYTE_W] = memory[base + AW'(k)];
      end
    end
  end

endmodule : data_memory

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed scenarios followed by a
// random phase, all compared against a byte-array reference model.
module tb_data_memory;

  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        rd;
  logic [31:0] rdata;

  logic [7:0] ref_mem [DEPTH];

  int n_assert = 0;
  int n_fail   = 0;

  data_memory #(.DEPTH(DEPTH)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .RDaddr_i   (addr),
    .RDdata_i   (wdata),
    .MemWrite_i (we),
    .MemRead_i  (rd),
    .RDdata_o   (rdata)
  );

  always #5 clk = ~clk;

  function automatic bit ref_in_range(input logic [31:0] a);
    longint unsigned ea;
    ea = longint'(a) - (longint'(a) % 4);
    return (ea + 3) < DEPTH;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a, input logic r);
    int b;
    if (r !== 1'b1 || !ref_in_range(a)) return 32'h0;
    b = int'(a) & ~3;
    return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [31:0] d, input logic w);
    int b;
    if (w === 1'b1 && ref_in_range(a)) begin
      b = int'(a) & ~3;
      for (int k = 0; k < 4; k++) ref_mem[b+k] = d[8*k +: 8];
    end
  endtask

  task automatic ref_clear();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < DEPTH; i++)
      check($sformatf("%s byte%0d", tag, i), {24'h0, dut.memory[i]}, {24'h0, ref_mem[i]});
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d,
                       input logic w, input logic r);
    addr  = a;
    wdata = d;
    we    = w;
    rd    = r;
  endtask

  // One rising edge: model the write, then settle just past the edge.
  task automatic step();
    @(posedge clk);
    if (rst_n === 1'b1) ref_write(addr, wdata, we);
    #1;
  endtask

  initial begin
    logic [31:0] ra, rdv;
    logic        rw, rr;

    drive(32'h0, 32'h0, 1'b0, 1'b1);
    rst_n = 1'b0;
    ref_clear();
    #12;
    check_mem("reset");
    check("reset rdata", rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Write 10 at 0x00: old word visible before the edge, new one after.
    drive(32'h0, 32'd10, 1'b1, 1'b1);
    #1;
    check("raw before edge", rdata, 32'h0);
    step();
    check("raw after edge", rdata, 32'd10);
    check_mem("wr0");

    drive(32'h4, 32'd10, 1'b1, 1'b1);
    step();
    check("wr4 rdata", rdata, 32'd10);
    check_mem("wr4");

    drive(32'h8, 32'd10, 1'b1, 1'b1);
    step();
    drive(32'hC, 32'd10, 1'b0, 1'b1);
    #1;
    check("read 0xC", rdata, 32'h0);
    step();
    check("read 0xC after edge", rdata, 32'h0);
    check_mem("no write 0xC");

    // Unaligned address, byte order pinned by constants.
    drive(32'h13, 32'h11223344, 1'b1, 1'b1);
    step();
    check("le byte16", {24'h0, dut.memory[16]}, 32'h44);
    check("le byte17", {24'h0, dut.memory[17]}, 32'h33);
    check("le byte18", {24'h0, dut.memory[18]}, 32'h22);
    check("le byte19", {24'h0, dut.memory[19]}, 32'h11);
    drive(32'h10, 32'h0, 1'b0, 1'b1);
    #1;
    check("read 0x10", rdata, 32'h11223344);

    // Out of range, including an address that would wrap in 32 bits.
    drive(32'h20, 32'hDEADBEEF, 1'b1, 1'b1);
    step();
    check("oor rdata", rdata, 32'h0);
    check_mem("oor 0x20");
    drive(32'hFFFF_FFFE, 32'hDEADBEEF, 1'b1, 1'b1);
    step();
    check("oor top rdata", rdata, 32'h0);
    check_mem("oor top");

    // Read enable gating.
    drive(32'h18, 32'hCAFEF00D, 1'b1, 1'b0);
    step();
    check("rd gated", rdata, 32'h0);
    drive(32'h18, 32'h0, 1'b0, 1'b0);
    #1;
    check("rd low", rdata, 32'h0);
    rd = 1'b1;
    #1;
    check("rd raised", rdata, 32'hCAFEF00D);

    // Unknown write enable must leave memory alone.
    drive(32'h1C, 32'h55555555, 1'bx, 1'b1);
    step();
    check_mem("we x");

    // Random phase.
    for (int n = 0; n < 300; n++) begin
      ra  = ($urandom_range(0, 7) == 0) ? $urandom() : 32'($urandom_range(0, 47));
      rdv = $urandom();
      rw  = 1'($urandom_range(0, 1));
      rr  = ($urandom_range(0, 3) != 0);
      drive(ra, rdv, rw, rr);
      #1;
      check($sformatf("rnd%0d pre", n), rdata, ref_word(ra, rr));
      step();
      check($sformatf("rnd%0d post", n), rdata, ref_word(ra, rr));
      if (n % 50 == 49) check_mem($sformatf("rnd%0d mem", n));
    end

    // Fill every word, then reset mid-cycle while a write is pending.
    for (int w = 0; w < DEPTH / 4; w++) begin
      drive(32'(w * 4), 32'hA5000000 | 32'(w), 1'b1, 1'b1);
      step();
    end
    check_mem("fill");
    drive(32'h0, 32'hFFFFFFFF, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    ref_clear();
    #1;
    check_mem("async reset");
    check("async reset rdata", rdata, 32'h0);
    @(posedge clk);
    #1;
    check_mem("write lost");
    check("write lost rdata", rdata, 32'h0);
    @(negedge clk);
    we    = 1'b0;
    rst_n = 1'b1;
    step();
    check("post reset rdata", rdata, 32'h0);
    check_mem("post reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_data_memory
